// File: rtl/ff_tester_pkg.sv
// ============================================================================
// Module  : ff_tester_pkg
// Brief   : Shared types and constants for the flip-flop bank tester.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ff_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_PULSE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int c_STIM_D = 0;
   localparam int c_STIM_J = 1;
   localparam int c_STIM_K = 2;
   localparam int c_STIM_T = 3;

   localparam int c_Q_D   = 0;
   localparam int c_NQ_D  = 1;
   localparam int c_Q_JK  = 2;
   localparam int c_NQ_JK = 3;
   localparam int c_Q_T   = 4;
   localparam int c_NQ_T  = 5;

   localparam logic [3:0] INIT_STIM     = 4'b0100;
   localparam logic [7:0] INIT_FAIL_IDX = 8'hFF;

   // Ideal bank response for the given Q states, in q_obs bit order.
   function automatic logic [5:0] expected_obs(input logic qd, input logic qjk, input logic qt);
      logic [5:0] v;
      v           = '0;
      v[c_Q_D]    = qd;
      v[c_NQ_D]   = ~qd;
      v[c_Q_JK]   = qjk;
      v[c_NQ_JK]  = ~qjk;
      v[c_Q_T]    = qt;
      v[c_NQ_T]   = ~qt;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ff_golden_model.sv
// ============================================================================
// Module  : ff_golden_model
// Brief   : Reference D/JK/T flip-flop states, stepped once per bank strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ff_golden_model
   import ff_tester_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] stim_i,
   input  logic       upd_i,
   input  logic       load_i,
   input  logic       load_t_i,
   output logic       q_d_o,
   output logic       q_jk_o,
   output logic       q_t_o
);

   logic q_d_q, q_d_d;
   logic q_jk_q, q_jk_d;
   logic q_t_q, q_t_d;

   always_comb begin
      q_d_d  = q_d_q;
      q_jk_d = q_jk_q;
      q_t_d  = q_t_q;
      if (upd_i) begin
         q_d_d = stim_i[c_STIM_D];
         unique case ({stim_i[c_STIM_J], stim_i[c_STIM_K]})
            2'b00:   q_jk_d = q_jk_q;
            2'b01:   q_jk_d = 1'b0;
            2'b10:   q_jk_d = 1'b1;
            default: q_jk_d = ~q_jk_q;
         endcase
         if (stim_i[c_STIM_T]) begin
            q_t_d = ~q_t_q;
         end
      end
      // The bank's T flop has no reset, so its state is adopted from the bank.
      if (load_i) begin
         q_t_d = load_t_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_d_q  <= 1'b0;
         q_jk_q <= 1'b0;
         q_t_q  <= 1'b0;
      end else begin
         q_d_q  <= q_d_d;
         q_jk_q <= q_jk_d;
         q_t_q  <= q_t_d;
      end
   end

   assign q_d_o  = q_d_q;
   assign q_jk_o = q_jk_q;
   assign q_t_o  = q_t_q;

endmodule

`default_nettype wire

// File: rtl/ff_bank_tester.sv
// ============================================================================
// Module  : ff_bank_tester
// Brief   : Drives the D/JK/T bank, strobes it and checks every response.
//           FF_TESTER_HALT_ON_ERR_EN: stop the run at the first mismatch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ff_bank_tester
   import ff_tester_pkg::*;
#(
   parameter int NUM_VECTORS   = 16,
   parameter int SETTLE_CYCLES = 3,
   parameter int PULSE_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [5:0] q_obs_i,
   output logic [3:0] stim_o,
   output logic       ff_clk_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [7:0] err_count_o,
   output logic [7:0] fail_vec_o,
   output logic [5:0] fail_obs_o
);

`ifdef FF_TESTER_HALT_ON_ERR_EN
   localparam logic c_HALT_ON_ERR = 1'b1;
`else
   localparam logic c_HALT_ON_ERR = 1'b0;
`endif

   localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] c_PULSE_LAST  = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] c_LAST_VEC    = 8'(NUM_VECTORS - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] vec_q, vec_d;
   logic       init_q, init_d;
   logic [3:0] stim_q, stim_d;
   logic       ff_clk_q, ff_clk_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [7:0] err_q, err_d;
   logic [7:0] fvec_q, fvec_d;
   logic [5:0] fobs_q, fobs_d;
   logic [5:0] sync1_q, sync2_q;

   logic       w_upd, w_load, w_mismatch;
   logic       w_model_d, w_model_jk, w_model_t;
   logic [5:0] w_expect;

   assign w_upd  = (state_q == ST_DRIVE) && (cnt_q == c_SETTLE_LAST);
   assign w_load = (state_q == ST_CHECK) && init_q;

   ff_golden_model u_model (
      .clk      (clk),
      .rst_n    (rst_n),
      .stim_i   (stim_q),
      .upd_i    (w_upd),
      .load_i   (w_load),
      .load_t_i (sync2_q[c_Q_T]),
      .q_d_o    (w_model_d),
      .q_jk_o   (w_model_jk),
      .q_t_o    (w_model_t)
   );

   // During the init check the observed Q_T is the reference by definition.
   assign w_expect   = expected_obs(w_model_d, w_model_jk, init_q ? sync2_q[c_Q_T] : w_model_t);
   assign w_mismatch = (sync2_q != w_expect);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      init_d  = init_q;
      stim_d  = stim_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fobs_d  = fobs_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_DRIVE;
               cnt_d   = 8'd0;
               vec_d   = 8'd0;
               init_d  = 1'b1;
               stim_d  = INIT_STIM;
               err_d   = 8'd0;
               fvec_d  = 8'd0;
               fobs_d  = 6'd0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == c_SETTLE_LAST) begin
               state_d = ST_PULSE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == c_PULSE_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == c_SETTLE_LAST) begin
               state_d = ST_CHECK;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_CHECK: begin
            cnt_d = 8'd0;
            if (w_mismatch) begin
               // A zero count marks the first failure; saturation keeps it non-zero.
               if (err_q == 8'd0) begin
                  fvec_d = init_q ? INIT_FAIL_IDX : vec_q;
                  fobs_d = sync2_q;
               end
               if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
            end
            if (w_mismatch && c_HALT_ON_ERR) begin
               state_d = ST_DONE;
            end else if (init_q) begin
               init_d  = 1'b0;
               vec_d   = 8'd0;
               stim_d  = 4'd0;
               state_d = ST_DRIVE;
            end else if (vec_q == c_LAST_VEC) begin
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + 8'd1;
               stim_d  = vec_d[3:0];
               state_d = ST_DRIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ff_clk_d = (state_d == ST_PULSE);
      busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d   = (state_d == ST_DONE);
      pass_d   = done_d && (err_d == 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         vec_q    <= 8'd0;
         init_q   <= 1'b0;
         stim_q   <= 4'd0;
         ff_clk_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 8'd0;
         fvec_q   <= 8'd0;
         fobs_q   <= 6'd0;
         sync1_q  <= 6'd0;
         sync2_q  <= 6'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         init_q   <= init_d;
         stim_q   <= stim_d;
         ff_clk_q <= ff_clk_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         fobs_q   <= fobs_d;
         sync1_q  <= q_obs_i;
         sync2_q  <= sync1_q;
      end
   end

   assign stim_o      = stim_q;
   assign ff_clk_o    = ff_clk_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_count_o = err_q;
   assign fail_vec_o  = fvec_q;
   assign fail_obs_o  = fobs_q;

endmodule

`default_nettype wire

// File: tb/tb_ff_bank_tester.sv
// ============================================================================
// Module  : tb_ff_bank_tester
// Brief   : Bench for ff_bank_tester with a behavioural bank and fault modes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ff_bank_tester;

   localparam int NV      = 16;
   localparam int SC      = 3;
   localparam int PC      = 2;
   localparam int VEC_CYC = 2 * SC + PC + 1;
`ifdef FF_TESTER_HALT_ON_ERR_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   typedef struct {
      logic       pass;
      logic [7:0] err;
      logic [7:0] fvec;
      logic [5:0] fobs;
      int         nvec;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [5:0] q_obs;
   logic [3:0] stim;
   logic       ff_clk, busy, done, pass;
   logic [7:0] err_count, fail_vec;
   logic [5:0] fail_obs;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ff_bank_tester #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .PULSE_CYCLES(PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .q_obs_i     (q_obs),
      .stim_o      (stim),
      .ff_clk_o    (ff_clk),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .err_count_o (err_count),
      .fail_vec_o  (fail_vec),
      .fail_obs_o  (fail_obs)
   );

   // Behavioural bank: 0 ideal, 1 Q_JK stuck at 0, 2 nQ_D tied to Q_D.
   int   fault_mode = 0;
   logic t_init = 1'b0;
   logic bank_load = 1'b0;
   logic b_d, b_jk, b_t;

   always @(posedge ff_clk or posedge bank_load) begin
      if (bank_load) begin
         b_d <= 1'b0; b_jk <= 1'b0; b_t <= t_init;
      end else begin
         b_d <= stim[0];
         case ({stim[1], stim[2]})
            2'b01:   b_jk <= 1'b0;
            2'b10:   b_jk <= 1'b1;
            2'b11:   b_jk <= ~b_jk;
            default: b_jk <= b_jk;
         endcase
         if (stim[3]) b_t <= ~b_t;
      end
   end

   always_comb begin
      q_obs = {~b_t, b_t, ~b_jk, b_jk, ~b_d, b_d};
      if (fault_mode == 1) q_obs[2] = 1'b0;
      if (fault_mode == 2) q_obs[1] = b_d;
   end

   // Monitor: stim seen at each strobe rise and each strobe high time.
   logic [3:0] obs_stim[$];
   int         obs_width[$];
   logic [3:0] exp_stim[$];
   res_t       exp_res[$];
   int         hi_cnt = 0;
   logic       ff_prev = 1'b0;

   always @(negedge clk) begin
      if (ff_clk && !ff_prev) obs_stim.push_back(stim);
      if (ff_clk) hi_cnt++;
      else if (ff_prev) begin obs_width.push_back(hi_cnt); hi_cnt = 0; end
      if (!rst_n) hi_cnt = 0;
      ff_prev = ff_clk;
   end

   function automatic res_t predict(input int mode, input logic t0);
      res_t r;
      logic bd, bjk, bt;
      logic [3:0] s;
      logic [5:0] ideal, obs;
      int errs;
      bd = 1'b0; bjk = 1'b0; bt = t0; errs = 0;
      r.fvec = 8'd0; r.fobs = 6'd0; r.nvec = 0;
      for (int k = -1; k < NV; k++) begin
         s = (k < 0) ? 4'b0100 : 4'(k);
         r.nvec++;
         bd = s[0];
         if (s[1] && s[2]) bjk = ~bjk;
         else if (s[1]) bjk = 1'b1;
         else if (s[2]) bjk = 1'b0;
         if (s[3]) bt = ~bt;
         ideal = {~bt, bt, ~bjk, bjk, ~bd, bd};
         obs = ideal;
         if (mode == 1) obs[2] = 1'b0;
         if (mode == 2) obs[1] = bd;
         if (obs !== ideal) begin
            if (errs == 0) begin
               r.fvec = (k < 0) ? 8'hFF : 8'(k);
               r.fobs = obs;
            end
            if (errs < 255) errs++;
            if (HALT) break;
         end
      end
      r.err  = 8'(errs);
      r.pass = (errs == 0);
      return r;
   endfunction

   task automatic launch(input int mode, input logic t0);
      res_t r;
      @(posedge clk); #1;
      fault_mode = mode; t_init = t0;
      bank_load = 1'b1; #1 bank_load = 1'b0;
      obs_stim.delete(); obs_width.delete(); exp_stim.delete();
      r = predict(mode, t0);
      exp_res.push_back(r);
      exp_stim.push_back(4'b0100);
      for (int k = 0; k < r.nvec - 1; k++) exp_stim.push_back(4'(k));
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit to);
      cyc = 0; to = 1'b0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (cyc > 5000) begin to = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (stim !== 4'd0) begin bad++; $display("FAIL reset_stim got=%h want=0", stim); end
      total++; if (ff_clk !== 1'b0) begin bad++; $display("FAIL reset_ffclk got=%b want=0", ff_clk); end
      total++; if ({busy, done, pass} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, pass}); end
      total++; if ({err_count, fail_vec, fail_obs} !== 22'd0) begin bad++; $display("FAIL reset_results got=%h/%h/%h want=0", err_count, fail_vec, fail_obs); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_ideal;
      int cyc; bit to; res_t r; logic [3:0] es, os; int w;
      launch(0, 1'b0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ideal_busy_rise got=%b want=1", busy); end
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to) begin bad++; $display("FAIL ideal_timeout got=timeout want=done"); end
      total++; if (cyc !== 17 * VEC_CYC) begin bad++; $display("FAIL ideal_cycles got=%0d want=%0d", cyc, 17 * VEC_CYC); end
      total++; if (pass !== r.pass || pass !== 1'b1) begin bad++; $display("FAIL ideal_pass got=%b want=1", pass); end
      total++; if (err_count !== r.err) begin bad++; $display("FAIL ideal_err got=%0d want=%0d", err_count, r.err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ideal_busy_end got=%b want=0", busy); end
      total++; if (obs_stim.size() !== exp_stim.size()) begin bad++; $display("FAIL ideal_pulses got=%0d want=%0d", obs_stim.size(), exp_stim.size()); end
      while (exp_stim.size() > 0 && obs_stim.size() > 0) begin
         es = exp_stim.pop_front(); os = obs_stim.pop_front();
         total++; if (os !== es) begin bad++; $display("FAIL ideal_stim got=%h want=%h", os, es); end
      end
      total++; if (obs_width.size() !== 17) begin bad++; $display("FAIL ideal_widths got=%0d want=17", obs_width.size()); end
      while (obs_width.size() > 0) begin
         w = obs_width.pop_front();
         total++; if (w !== PC) begin bad++; $display("FAIL ideal_pulse_width got=%0d want=%0d", w, PC); end
      end
   endtask

   task automatic test_t_powerup;
      int cyc; bit to; res_t r;
      launch(0, 1'b1);
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to) begin bad++; $display("FAIL tpow_timeout got=timeout want=done"); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL tpow_pass got=%b want=1", pass); end
      total++; if (err_count !== r.err) begin bad++; $display("FAIL tpow_err got=%0d want=%0d", err_count, r.err); end
   endtask

   task automatic test_jk_stuck;
      int cyc; bit to; res_t r;
      launch(1, 1'b0);
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to) begin bad++; $display("FAIL jk_timeout got=timeout want=done"); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL jk_pass got=%b want=0", pass); end
      total++; if (fail_vec !== 8'd2) begin bad++; $display("FAIL jk_fail_vec got=%0d want=2", fail_vec); end
      total++; if (fail_obs[2] !== 1'b0) begin bad++; $display("FAIL jk_fail_obs_bit2 got=%b want=0", fail_obs[2]); end
      total++; if (fail_obs !== r.fobs) begin bad++; $display("FAIL jk_fail_obs got=%b want=%b", fail_obs, r.fobs); end
      total++; if (err_count !== r.err) begin bad++; $display("FAIL jk_err got=%0d want=%0d", err_count, r.err); end
      total++; if (cyc !== r.nvec * VEC_CYC) begin bad++; $display("FAIL jk_cycles got=%0d want=%0d", cyc, r.nvec * VEC_CYC); end
   endtask

   task automatic test_nqd_tied;
      int cyc; bit to; res_t r;
      launch(2, 1'b0);
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to) begin bad++; $display("FAIL nqd_timeout got=timeout want=done"); end
      total++; if (fail_vec !== 8'hFF) begin bad++; $display("FAIL nqd_fail_vec got=%h want=ff", fail_vec); end
      total++; if (err_count !== (HALT ? 8'd1 : 8'd17)) begin bad++; $display("FAIL nqd_err got=%0d want=%0d", err_count, HALT ? 1 : 17); end
      total++; if (cyc !== (HALT ? VEC_CYC : 17 * VEC_CYC)) begin bad++; $display("FAIL nqd_cycles got=%0d want=%0d", cyc, HALT ? VEC_CYC : 17 * VEC_CYC); end
      total++; if (pass !== 1'b0 || fail_obs !== r.fobs) begin bad++; $display("FAIL nqd_pass_obs got=%b/%b want=0/%b", pass, fail_obs, r.fobs); end
   endtask

   task automatic test_reset_mid_run;
      int cyc; bit to; res_t r; int guard;
      launch(0, 1'b0);
      guard = 0;
      while (!(ff_clk === 1'b1 && obs_stim.size() == 7) && guard < 500) begin
         @(posedge clk); #2;
         guard++;
      end
      total++; if (guard >= 500) begin bad++; $display("FAIL midrst_reach_vec5 got=timeout want=pulse"); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (ff_clk !== 1'b0) begin bad++; $display("FAIL midrst_ffclk got=%b want=0", ff_clk); end
      total++; if ({stim, busy, done, pass, err_count, fail_vec, fail_obs} !== 29'd0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", {stim, busy, done, pass, err_count, fail_vec, fail_obs}); end
      void'(exp_res.pop_back());
      @(negedge clk) rst_n = 1'b1;
      launch(0, 1'b0);
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to || pass !== 1'b1) begin bad++; $display("FAIL midrst_rerun got=to%0b/pass%b want=to0/pass1", to, pass); end
      total++; if (err_count !== r.err) begin bad++; $display("FAIL midrst_err got=%0d want=%0d", err_count, r.err); end
   endtask

   task automatic test_back_to_back;
      int cyc; bit to; res_t r; logic [3:0] es, os;
      launch(2, 1'b0);
      wait_done(cyc, to);
      void'(exp_res.pop_front());
      total++; if (to || err_count === 8'd0) begin bad++; $display("FAIL b2b_setup got=err%0d want=nonzero", err_count); end
      launch(0, 1'b0);
      total++; if ({done, pass, err_count, fail_vec, fail_obs} !== 24'd0) begin bad++; $display("FAIL b2b_clear got=%h want=0", {done, pass, err_count, fail_vec, fail_obs}); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(cyc, to);
      r = exp_res.pop_front();
      total++; if (to) begin bad++; $display("FAIL b2b_timeout got=timeout want=done"); end
      total++; if (cyc + 41 !== 17 * VEC_CYC) begin bad++; $display("FAIL b2b_cycles got=%0d want=%0d", cyc + 41, 17 * VEC_CYC); end
      total++; if (pass !== r.pass || err_count !== r.err) begin bad++; $display("FAIL b2b_result got=%b/%0d want=%b/%0d", pass, err_count, r.pass, r.err); end
      total++; if (obs_stim.size() !== exp_stim.size()) begin bad++; $display("FAIL b2b_pulses got=%0d want=%0d", obs_stim.size(), exp_stim.size()); end
      while (exp_stim.size() > 0 && obs_stim.size() > 0) begin
         es = exp_stim.pop_front(); os = obs_stim.pop_front();
         total++; if (os !== es) begin bad++; $display("FAIL b2b_stim got=%h want=%h", os, es); end
      end
      repeat (3) @(negedge clk);
      total++; if (stim !== 4'hF || done !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%h/%b want=f/1", stim, done); end
   endtask

   initial begin
      test_reset;
      test_ideal;
      test_t_powerup;
      test_jk_stuck;
      test_nqd_tied;
      test_reset_mid_run;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ff_bank_tester.md
# ff_bank_tester

Self-checking stimulus generator and response checker for the D/JK/T flip-flop bank. It drives the bank's 4-bit switch-style input, issues the bank clock strobe, and reads back the 6 Q/nQ outputs. It compares each response against an internal golden model and reports pass/fail, error count and first-failure details. It sits on the initiator side of the bank's sw/btnC to led interface and replaces manual switch-and-button testing on the board.

## Interface
- `NUM_VECTORS`, 16: stimulus vectors per run, range 1..256.
- `SETTLE_CYCLES`, 3: wait cycles before the strobe and before the sample, range 3..255.
- `PULSE_CYCLES`, 2: high time of `ff_clk`, range 1..255.
- `Clock` in 1: single system clock; all logic is rising-edge.
- `nReset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request.
- `q_obs` in 6: bank outputs `{nQ_T,Q_T,nQ_JK,Q_JK,nQ_D,Q_D}`.
- `stim` out 4: bank inputs `{T,K,J,D}`.
- `ff_clk` out 1: bank clock strobe, registered.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until the next accepted `start`.
- `pass` out 1: valid when `done` is 1; 1 when no mismatch occurred.
- `err_count` out 8: saturating mismatch count.
- `fail_vec` out 8: index of the first failing vector (0xFF = init check).
- `fail_obs` out 6: `q_obs` captured at the first failure.

## Operation
- `q_obs` passes through a 2-flop synchronizer, because the bank is clocked by `ff_clk`, not `Clock`.
- FSM states: IDLE, DRIVE, PULSE, WAIT, CHECK, DONE.
- In IDLE or DONE, `start`=1 clears `err_count`, `fail_*`, `pass` and `done`, and enters DRIVE for the init vector. `start` is ignored in all other states.
- Init vector: `stim`=4'b0100 (D=0, J=0, K=1, T=0).
  - Expected response: Q_D=0, Q_JK=0.
  - The observed Q_T is adopted as the model's T state, because the T flop has no reset.
  - A failure here records `fail_vec`=0xFF.
- Vectors i=0..NUM_VECTORS-1 follow. `stim`=i[3:0] (binary count).
- DRIVE: set `stim` on entry, hold SETTLE_CYCLES cycles, then go to PULSE.
- PULSE: `ff_clk`=1 for PULSE_CYCLES cycles, then go to WAIT. The golden model updates once, on PULSE entry.
- WAIT: `ff_clk`=0 for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (one cycle): compare the synchronized `q_obs` with the model.
  - Each Q must match its model bit.
  - Each nQ must equal ~Q of the model.
  - Any mismatched bit counts one error for the vector.
  - On the first error, capture `fail_vec` and `fail_obs`.
  - Then go to DRIVE for the next vector, or to DONE after the last one.
- Golden model next state:
  - D flop: Q=D.
  - JK flop: 00 hold, 01 reset, 10 set, 11 toggle.
  - T flop: toggle when T=1.
- DONE: `done`=1, `busy`=0, `pass`=(`err_count`==0). `stim` holds its last value.
- `err_count` saturates at 255.

## Timing
- Reset values: `stim`=0, `ff_clk`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_obs`=0. FSM resets to IDLE.
- Reset is asynchronous. Asserting it mid-run forces `ff_clk` low immediately and aborts the run with no partial result.
- `busy` rises on the cycle after `start` is accepted.
- Per-vector latency is 2·SETTLE_CYCLES + PULSE_CYCLES + 1 cycles (9 with defaults).
- A full default run takes 17·9 = 153 cycles from `busy` rising to `done` rising.
- `start` and the final CHECK cannot coincide, since `start` is ignored while busy.

## Configuration
- `FF_TESTER_HALT_ON_ERR_EN` defined: the first mismatch goes from CHECK directly to DONE with `pass`=0 and `err_count`=1. Remaining vectors are not applied.
- Not defined: all vectors always run, and `err_count` accumulates.

## Structure
- Shared package `ff_tester_pkg` holds:
  - the state enum;
  - stim bit indices (D=0, J=1, K=2, T=3);
  - `q_obs` bit indices;
  - `INIT_STIM`=4'b0100;
  - `INIT_FAIL_IDX`=8'hFF.
- One sub-module, `ff_golden_model`. Inputs: `stim`, an update strobe, a load strobe and load value for the T state. Outputs: the expected Q_D, Q_JK and Q_T. It has the same clock and reset as the parent.

## Test plan
- Ideal bank model, defaults, `start` pulse → after 153 cycles `done`=1, `pass`=1, `err_count`=0, with exactly 17 `ff_clk` pulses of 2 cycles each.
- T flop powered up at Q=1 → init adopts Q_T=1, and the run passes.
- Bank model with Q_JK stuck at 0 → `pass`=0, `fail_vec`=2 (J=1, K=0 expects Q_JK=1), `fail_obs` bit2=0.
- Bank model with nQ_D tied equal to Q_D → `fail_vec`=0xFF, and `err_count`=17 without the halt macro; with `FF_TESTER_HALT_ON_ERR_EN` defined, `err_count`=1 and `done` rises 9 cycles after `busy`.
- `nReset` asserted while `ff_clk`=1 in vector 5 → `ff_clk`=0 in the same cycle, and all outputs at reset values; a new `start` then completes with `pass`=1.
- `start` pulsed while `busy` → ignored, and the run length is unchanged. `start` in DONE → counters clear and a new run begins.
